alu_wb_stage: RTL and testbench

Registered writeback stage directly downstream of the 32-bit ALU. Captures the ALU result and its flag outputs (CarryOut, Zero, Overflow, negative) under a valid/ready handshake. Derives the CR0 field, maintains the architectural XER bits SO/OV/CA, and presents one ordered writeback per accepted operation to the register-file write port.

---
 rtl/alu_wb_stage.sv | 176 +++++++++++++++++
 tb/tb_alu_wb_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: registered writeback stage behind the 32-bit ALU.
// Captures result/flags under valid/ready, derives CR0, keeps XER SO/OV/CA,
// and hands one ordered writeback per accepted operation to the register file.
// Build option: define ALU_WB_SKID_EN for a two-entry (main + skid) buffer
// whose in_ready comes straight from a flop; otherwise a single register with
// a combinational in_ready.
module alu_wb_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic          in_carry,
  input  logic          in_zero,
  input  logic          in_ovf,
  input  logic          in_neg,
  input  logic          in_rc,
  input  logic          in_oe,
  input  logic          in_ca_en,
  input  logic [RW-1:0] in_rd,
  input  logic          xer_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_rd,
  output logic [3:0]    out_cr0,
  output logic          out_cr0_we,
  output logic          xer_so,
  output logic          xer_ov,
  output logic          xer_ca
);

  typedef struct packed {
    logic [DW-1:0] result;
    logic [RW-1:0] rd;
    logic [3:0]    cr0;
    logic          cr0_we;
  } wb_t;

  // CR0 is {LT, GT, EQ, SO}; zero comes from the ALU as given.
  function automatic logic [3:0] cr0_calc(input logic neg, input logic zero, input logic so);
    cr0_calc = {neg, (~neg) & (~zero), zero, so};
  endfunction

  logic so_r, ov_r, ca_r;
  logic so_base_s, ov_base_s, ca_base_s;
  logic so_n_s, ov_n_s, ca_n_s;
  logic in_fire_s;
  logic out_fire_s;
  logic main_valid_r;
  wb_t  main_r;
  wb_t  wb_in_s;

  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = main_valid_r && out_ready;

  // Next XER bits: a clear pulse applies first, then the accepted op's update.
  always_comb begin
    so_base_s = so_r;
    ov_base_s = ov_r;
    ca_base_s = ca_r;
    if (xer_clr) begin
      so_base_s = 1'b0;
      ov_base_s = 1'b0;
      ca_base_s = 1'b0;
    end else begin
      so_base_s = so_r;
      ov_base_s = ov_r;
      ca_base_s = ca_r;
    end
    so_n_s = so_base_s;
    ov_n_s = ov_base_s;
    ca_n_s = ca_base_s;
    if (in_fire_s) begin
      so_n_s = so_base_s | (in_oe & in_ovf);
      ov_n_s = in_oe ? in_ovf : ov_base_s;
      ca_n_s = in_ca_en ? in_carry : ca_base_s;
    end else begin
      so_n_s = so_base_s;
      ov_n_s = ov_base_s;
      ca_n_s = ca_base_s;
    end
  end

  // Bundle as it will be written back; CR0 SO sees this op's own update.
  always_comb begin
    wb_in_s.result = in_result;
    wb_in_s.rd     = in_rd;
    wb_in_s.cr0    = cr0_calc(in_neg, in_zero, so_n_s);
    wb_in_s.cr0_we = in_rc;
  end

  // Architectural XER register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      so_r <= 1'b0;
      ov_r <= 1'b0;
      ca_r <= 1'b0;
    end else begin
      so_r <= so_n_s;
      ov_r <= ov_n_s;
      ca_r <= ca_n_s;
    end
  end

`ifdef ALU_WB_SKID_EN
  logic skid_valid_r;
  wb_t  skid_r;

  // Ready is a pure flop output: no path from out_ready.
  assign in_ready = !skid_valid_r;

  // Main + skid buffer: skid absorbs the one bundle accepted during a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_r       <= '0;
      skid_valid_r <= 1'b0;
      skid_r       <= '0;
    end else if (out_fire_s) begin
      if (skid_valid_r) begin
        main_r       <= skid_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (in_fire_s) begin
        main_r       <= wb_in_s;
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
    end else if (in_fire_s) begin
      if (main_valid_r) begin
        skid_r       <= wb_in_s;
        skid_valid_r <= 1'b1;
      end else begin
        main_r       <= wb_in_s;
        main_valid_r <= 1'b1;
      end
    end else begin
      main_valid_r <= main_valid_r;
      skid_valid_r <= skid_valid_r;
    end
  end
`else
  // Single entry: a draining entry can be replaced in the same edge.
  assign in_ready = !main_valid_r || out_ready;

  // Single output register; payload holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_r       <= '0;
    end else if (in_fire_s) begin
      main_r       <= wb_in_s;
      main_valid_r <= 1'b1;
    end else if (out_fire_s) begin
      main_valid_r <= 1'b0;
    end else begin
      main_valid_r <= main_valid_r;
    end
  end
`endif

  assign out_valid  = main_valid_r;
  assign out_result = main_r.result;
  assign out_rd     = main_r.rd;
  assign out_cr0    = main_r.cr0;
  assign out_cr0_we = main_r.cr0_we;
  assign xer_so     = so_r;
  assign xer_ov     = ov_r;
  assign xer_ca     = ca_r;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed testbench for alu_wb_stage. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled at that point or 1 unit later.
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carry, in_zero, in_ovf, in_neg;
  logic        in_rc, in_oe, in_ca_en;
  logic [4:0]  in_rd;
  logic        xer_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [3:0]  out_cr0;
  logic        out_cr0_we;
  logic        xer_so, xer_ov, xer_ca;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ALU_WB_SKID_EN
  localparam int EXP_HELD = 2;
`else
  localparam int EXP_HELD = 1;
`endif

  alu_wb_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carry(in_carry), .in_zero(in_zero), .in_ovf(in_ovf), .in_neg(in_neg),
    .in_rc(in_rc), .in_oe(in_oe), .in_ca_en(in_ca_en), .in_rd(in_rd),
    .xer_clr(xer_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_cr0(out_cr0), .out_cr0_we(out_cr0_we),
    .xer_so(xer_so), .xer_ov(xer_ov), .xer_ca(xer_ca)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one bundle for one edge (stage assumed ready), then drop in_valid.
  task automatic send(input logic [31:0] res, input logic c, input logic z,
                      input logic o, input logic n, input logic rc,
                      input logic oe, input logic ca, input logic [4:0] rd,
                      input logic clr);
    in_valid = 1'b1; in_result = res; in_carry = c; in_zero = z; in_ovf = o;
    in_neg = n; in_rc = rc; in_oe = oe; in_ca_en = ca; in_rd = rd; xer_clr = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; xer_clr = 1'b0;
  endtask

  task automatic set_fields(input logic [4:0] rd);
    in_result = {27'd0, rd}; in_carry = 1'b0; in_zero = 1'b0; in_ovf = 1'b0;
    in_neg = 1'b0; in_rc = 1'b1; in_oe = 1'b0; in_ca_en = 1'b0; in_rd = rd;
  endtask

  int sent, got, cyc, first_held;
  logic [4:0] exp_rd;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; xer_clr = 1'b0;
    set_fields(5'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_xer", {29'd0, xer_so, xer_ov, xer_ca}, 32'd0);
    check("rst_payload", {22'd0, out_rd, out_cr0, out_cr0_we}, 32'd0);

    // Zero result with record bit
    send(32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0);
    check("z_valid", {31'd0, out_valid}, 32'd1);
    check("z_cr0", {28'd0, out_cr0}, 32'h2);
    check("z_cr0_we", {31'd0, out_cr0_we}, 32'd1);
    check("z_rd", {27'd0, out_rd}, 32'd7);

    // Overflow sets OV and SO; a later clean op clears OV but SO sticks
    send(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0);
    check("ov1_cr0", {28'd0, out_cr0}, 32'h9);
    check("ov1_ov", {31'd0, xer_ov}, 32'd1);
    check("ov1_result", out_result, 32'h8000_0000);
    send(32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    check("ov2_ov", {31'd0, xer_ov}, 32'd0);
    check("ov2_so", {31'd0, xer_so}, 32'd1);
    check("ov2_cr0", {28'd0, out_cr0}, 32'h5);

    // Build SO=OV=CA=1, then clear with a same-cycle fire that sets CA only
    send(32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
    check("xer_all_set", {29'd0, xer_so, xer_ov, xer_ca}, 32'h7);
    send(32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
    check("clrfire_xer", {29'd0, xer_so, xer_ov, xer_ca}, 32'h1);
    check("clrfire_cr0", {28'd0, out_cr0}, 32'h4);
    check("clrfire_cr0_we", {31'd0, out_cr0_we}, 32'd0);
    // Clear with no fire
    xer_clr = 1'b1;
    @(posedge clk); #1;
    xer_clr = 1'b0;
    check("clr_only_xer", {29'd0, xer_so, xer_ov, xer_ca}, 32'h0);
    check("drained_valid", {31'd0, out_valid}, 32'd0);
    // CA untouched when not enabled
    send(32'h0000_0009, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0);
    check("ca_hold", {31'd0, xer_ca}, 32'd0);
    @(posedge clk); #1;

    // Stream rd=1..4 with out_ready low for 3 cycles
    sent = 1; got = 0; cyc = 0; first_held = -1; exp_rd = 5'd1;
    while (got < 4 && cyc < 40) begin
      out_ready = !(cyc >= 2 && cyc < 5);
      if (sent <= 4) begin
        in_valid = 1'b1;
        set_fields(sent[4:0]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready && first_held < 0) first_held = (sent - 1) - got;
      if (out_valid && out_ready) begin
        check("stream_rd", {27'd0, out_rd}, {27'd0, exp_rd});
        exp_rd = exp_rd + 5'd1;
        got++;
      end else if (out_valid) begin
        check("stall_hold_rd", {27'd0, out_rd}, {27'd0, exp_rd});
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", got, 32'd4);
    check("stream_held_at_block", first_held, EXP_HELD);

    // Reset while holding a bundle with SO set, racing clr and a fire
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h0000_00AA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_so", {31'd0, xer_so}, 32'd1);
    rst_n = 1'b0; in_valid = 1'b1; xer_clr = 1'b1; in_oe = 1'b1; in_ovf = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; xer_clr = 1'b0;
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_so", {31'd0, xer_so}, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_rd", {27'd0, out_rd}, 32'd0);

    // Back-to-back 8 bundles at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      set_fields(5'(i + 10));
      #1;
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      check("b2b_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_rd", {27'd0, out_rd}, i + 10);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
